// File: rtl/pipo_write_arbiter_if.sv
// Write-port bundle between two requesters and the PIPO bank arbiter.
// LOCK0/LOCK1 exist only when PIPO_ARB_LOCK_EN is defined.
interface pipo_write_arbiter_if #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
);
    logic             REQ0;
    logic [AW-1:0]    ADDR0;
    logic [N-1:0]     DATA0;
    logic             REQ1;
    logic [AW-1:0]    ADDR1;
    logic [N-1:0]     DATA1;
`ifdef PIPO_ARB_LOCK_EN
    logic             LOCK0;
    logic             LOCK1;
`endif
    logic             GNT0;
    logic             GNT1;
    logic [DEPTH-1:0] EN;
    logic [N-1:0]     D_OUT;
    logic             ERR;

    modport master (
        output REQ0, ADDR0, DATA0, REQ1, ADDR1, DATA1,
`ifdef PIPO_ARB_LOCK_EN
        output LOCK0, LOCK1,
`endif
        input  GNT0, GNT1, EN, D_OUT, ERR
    );

    modport slave (
        input  REQ0, ADDR0, DATA0, REQ1, ADDR1, DATA1,
`ifdef PIPO_ARB_LOCK_EN
        input  LOCK0, LOCK1,
`endif
        output GNT0, GNT1, EN, D_OUT, ERR
    );
endinterface

// File: rtl/pipo_write_arbiter.sv
// Round-robin arbiter sharing one PIPO register bank between two writers.
// Optional burst locking is enabled by defining PIPO_ARB_LOCK_EN.
module pipo_write_arbiter #(
    parameter int N        = 8,
    parameter int DEPTH    = 4,
    parameter int LOCK_MAX = 4
) (
    input logic                CLK,
    input logic                RESET,
    pipo_write_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || LOCK_MAX < 1) begin : g_cfg_check
        $error("pipo_write_arbiter: DEPTH must be >= 2 and LOCK_MAX >= 1");
    end

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    // Out-of-range indices decode to all-zero, which is what flags ERR.
    function automatic logic [DEPTH-1:0] addr_decode(input logic [AW-1:0] a);
        logic [DEPTH-1:0] r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            r[i] = (a == AW'(i));
        end
        return r;
    endfunction

    state_t           state_p0, state_p1;
    logic             last_p0, last_p1;
    logic             gnt0_p0, gnt0_p1;
    logic             gnt1_p0, gnt1_p1;
    logic [DEPTH-1:0] en_p0, en_p1;
    logic [N-1:0]     dout_p0, dout_p1;
    logic             err_p0, err_p1;
    logic [AW-1:0]    addr_sel;
    logic             hold0, hold1;

`ifdef PIPO_ARB_LOCK_EN
    localparam int LCW = $clog2(LOCK_MAX + 1);
    logic [LCW-1:0] lock_cnt_p0, lock_cnt_p1;

    // Counter holds extra grants beyond the first; stay while below LOCK_MAX-1.
    assign hold0 = (state_p1 == G0) && bus.REQ0 && bus.LOCK0 &&
                   (lock_cnt_p1 < LCW'(LOCK_MAX - 1));
    assign hold1 = (state_p1 == G1) && bus.REQ1 && bus.LOCK1 &&
                   (lock_cnt_p1 < LCW'(LOCK_MAX - 1));
`else
    assign hold0 = 1'b0;
    assign hold1 = 1'b0;
`endif

    // ---- stage p0: decide next grant from REQ sampled at this edge ----
    always_comb begin
        state_p0 = IDLE;
        last_p0  = last_p1;
        dout_p0  = dout_p1;
        addr_sel = '0;
`ifdef PIPO_ARB_LOCK_EN
        lock_cnt_p0 = '0;
`endif
        if (hold0) begin
            state_p0 = G0;
`ifdef PIPO_ARB_LOCK_EN
            lock_cnt_p0 = lock_cnt_p1 + 1'b1;
`endif
        end else if (hold1) begin
            state_p0 = G1;
`ifdef PIPO_ARB_LOCK_EN
            lock_cnt_p0 = lock_cnt_p1 + 1'b1;
`endif
        end else begin
            case ({bus.REQ1, bus.REQ0})
                2'b01:   state_p0 = G0;
                2'b10:   state_p0 = G1;
                2'b11:   state_p0 = last_p1 ? G0 : G1;
                default: state_p0 = IDLE;
            endcase
        end

        case (state_p0)
            G0: begin
                last_p0  = 1'b0;
                addr_sel = bus.ADDR0;
                dout_p0  = bus.DATA0;
            end
            G1: begin
                last_p0  = 1'b1;
                addr_sel = bus.ADDR1;
                dout_p0  = bus.DATA1;
            end
            default: begin
                last_p0  = last_p1;
                addr_sel = '0;
                dout_p0  = dout_p1;
            end
        endcase

        gnt0_p0 = (state_p0 == G0);
        gnt1_p0 = (state_p0 == G1);
        en_p0   = (state_p0 != IDLE) ? addr_decode(addr_sel) : '0;
        err_p0  = (state_p0 != IDLE) && (en_p0 == '0);
    end

    // ---- stage p1: registered grant and bank drive ----
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_p1 <= IDLE;
            last_p1  <= 1'b1;
            gnt0_p1  <= 1'b0;
            gnt1_p1  <= 1'b0;
            en_p1    <= '0;
            dout_p1  <= '0;
            err_p1   <= 1'b0;
        end else begin
            state_p1 <= state_p0;
            last_p1  <= last_p0;
            gnt0_p1  <= gnt0_p0;
            gnt1_p1  <= gnt1_p0;
            en_p1    <= en_p0;
            dout_p1  <= dout_p0;
            err_p1   <= err_p0;
        end
    end

`ifdef PIPO_ARB_LOCK_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lock_cnt_p1 <= '0;
        end else begin
            lock_cnt_p1 <= lock_cnt_p0;
        end
    end
`endif

    assign bus.GNT0  = gnt0_p1;
    assign bus.GNT1  = gnt1_p1;
    assign bus.EN    = en_p1;
    assign bus.D_OUT = dout_p1;
    assign bus.ERR   = err_p1;

    a_gnt_excl: assert property (@(posedge CLK) disable iff (RESET)
        !(gnt0_p1 && gnt1_p1));
    a_en_onehot: assert property (@(posedge CLK) disable iff (RESET)
        $onehot0(en_p1));
    a_en_needs_gnt: assert property (@(posedge CLK) disable iff (RESET)
        (en_p1 != '0) |-> (gnt0_p1 || gnt1_p1));
    a_err_needs_gnt: assert property (@(posedge CLK) disable iff (RESET)
        err_p1 |-> ((gnt0_p1 || gnt1_p1) && (en_p1 == '0)));
endmodule
